// File: rtl/training_sequencer.sv
// training_sequencer
// Holds up to DEPTH labelled training samples written from the pins, then
// drives a perceptron core through repeated training epochs. For each sample
// it pulses go together with feature word 0, streams the other words on
// in_val, waits for p_done, and answers with an update pulse and a correct
// flag. A run ends after the first error-free epoch, after MAX_EPOCHS epochs,
// or when the core fails to answer within TIMEOUT cycles.
//
// Ports
//   clk, reset_l           : clock, synchronous active-low reset
//   ld_wr/ld_data/ld_label : sample load, one 6-bit word per ld_wr (IDLE only)
//   ld_clear               : empty the sample store (IDLE only, beats ld_wr)
//   start                  : begin a training run (IDLE only)
//   p_done/p_class         : core result, only looked at while waiting
//   go/in_val              : sample start strobe and feature bus to the core
//   update/correct         : per-sample weight-update strobe and its flag
//   busy/full/fin          : status; fin is a one-cycle end-of-run strobe
//   converged/timeout_err  : outcome of the last run, held until next start
//   epoch_cnt              : epochs completed in the current/last run
//   dbg_state              : current FSM state (IDLE encodes as 0)
//
// Handshake: there is no backpressure anywhere. go, update and fin are
// single-cycle strobes the receiver must take in the cycle they are high;
// in_val carries feature k exactly k cycles after go; correct is meaningful
// only while update is high; p_done is a single-cycle strobe that is honoured
// only in the wait state and ignored at any other time.
module training_sequencer #(
    parameter int NUM_FEAT   = 4,
    parameter int DEPTH      = 8,
    parameter int MAX_EPOCHS = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       ld_wr,
    input  logic [5:0] ld_data,
    input  logic       ld_label,
    input  logic       ld_clear,
    input  logic       start,
    input  logic       p_done,
    input  logic       p_class,
    output logic       go,
    output logic [5:0] in_val,
    output logic       update,
    output logic       correct,
    output logic       busy,
    output logic       full,
    output logic       fin,
    output logic       converged,
    output logic       timeout_err,
    output logic [3:0] epoch_cnt,
    output logic [2:0] dbg_state
);
    localparam int SW = $clog2(DEPTH);
    localparam int WW = $clog2(NUM_FEAT);
    localparam int CW = SW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GO    = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_UPD   = 3'd4,
        S_EPOCH = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wr_word_q, wr_word_d;
    logic [SW-1:0] sample_q, sample_d;
    logic [WW-1:0] feat_q, feat_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]    errors_q, errors_d;
    logic [3:0]    epoch_q, epoch_d;
    logic          correct_q, correct_d;
    logic          converged_q, converged_d;
    logic          timeout_q, timeout_d;

    // Sample store: write-enabled arrays, contents are not reset.
    logic [5:0]       feat_mem [DEPTH][NUM_FEAT];
    logic [DEPTH-1:0] lbl_mem;

    logic          store_full, wr_en, wr_last, last_sample;
    logic [3:0]    epoch_next;
    logic [WW-1:0] rd_word;

    assign store_full  = (count_q == CW'(DEPTH));
    assign wr_en       = (state_q == S_IDLE) && ld_wr && !ld_clear && !store_full;
    assign wr_last     = (wr_word_q == WW'(NUM_FEAT - 1));
    assign last_sample = ((CW'(sample_q) + CW'(1)) == count_q);
    assign epoch_next  = epoch_q + 4'd1;

    // Write pointer: the sample index is the sample count itself, so a
    // partially written sample never shows up in the count.
    always_comb begin
        count_d   = count_q;
        wr_word_d = wr_word_q;
        if ((state_q == S_IDLE) && ld_clear) begin
            count_d   = '0;
            wr_word_d = '0;
        end else if (wr_en) begin
            if (wr_last) begin
                wr_word_d = '0;
                count_d   = count_q + CW'(1);
            end else begin
                wr_word_d = wr_word_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            feat_mem[count_q[SW-1:0]][wr_word_q] <= ld_data;
            if (wr_last) begin
                lbl_mem[count_q[SW-1:0]] <= ld_label;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_word_q   <= '0;
            sample_q    <= '0;
            feat_q      <= '0;
            wait_cnt_q  <= '0;
            errors_q    <= '0;
            epoch_q     <= '0;
            correct_q   <= 1'b0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_word_q   <= wr_word_d;
            sample_q    <= sample_d;
            feat_q      <= feat_d;
            wait_cnt_q  <= wait_cnt_d;
            errors_q    <= errors_d;
            epoch_q     <= epoch_d;
            correct_q   <= correct_d;
            converged_q <= converged_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and run bookkeeping.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        feat_d      = feat_q;
        wait_cnt_d  = wait_cnt_q;
        errors_d    = errors_q;
        epoch_d     = epoch_q;
        correct_d   = correct_q;
        converged_d = converged_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sample_d    = '0;
                    errors_d    = '0;
                    epoch_d     = '0;
                    converged_d = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = (count_q != '0) ? S_GO : S_FIN;
                end
            end
            S_GO: begin
                feat_d  = WW'(1);
                state_d = S_FEED;
            end
            S_FEED: begin
                if (feat_q == WW'(NUM_FEAT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    feat_d = feat_q + WW'(1);
                end
            end
            S_WAIT: begin
                // A response in the last allowed cycle still counts.
                if (p_done) begin
                    correct_d = (p_class == lbl_mem[sample_q]);
                    if ((p_class != lbl_mem[sample_q]) && (errors_q != 4'hF)) begin
                        errors_d = errors_q + 4'd1;
                    end
                    state_d = S_UPD;
                end else if (wait_cnt_q == TW'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_UPD: begin
                if (last_sample) begin
                    state_d = S_EPOCH;
                end else begin
                    sample_d = sample_q + SW'(1);
                    state_d  = S_GO;
                end
            end
            S_EPOCH: begin
                epoch_d = epoch_next;
                if (errors_q == '0) begin
                    converged_d = 1'b1;
                    state_d     = S_FIN;
                end else if (epoch_next == 4'(MAX_EPOCHS)) begin
                    state_d = S_FIN;
                end else begin
                    errors_d = '0;
                    sample_d = '0;
                    state_d  = S_GO;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        rd_word     = (state_q == S_GO) ? '0 : feat_q;
        go          = (state_q == S_GO);
        in_val      = ((state_q == S_GO) || (state_q == S_FEED)) ? feat_mem[sample_q][rd_word] : 6'd0;
        update      = (state_q == S_UPD);
        correct     = (state_q == S_UPD) && correct_q;
        busy        = (state_q != S_IDLE);
        full        = store_full;
        fin         = (state_q == S_FIN);
        converged   = converged_q;
        timeout_err = timeout_q;
        epoch_cnt   = epoch_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_training_sequencer.sv
module tb_training_sequencer;
    localparam int NUM_FEAT   = 4;
    localparam int DEPTH      = 8;
    localparam int MAX_EPOCHS = 15;
    localparam int TIMEOUT    = 255;
    localparam int W          = 12;
    localparam int BUDGET     = 4000;
    localparam logic [2:0] EV_FEAT = 3'd1;
    localparam logic [2:0] EV_UPD  = 3'd2;
    localparam logic [2:0] EV_FIN  = 3'd3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       ld_wr = 1'b0;
    logic [5:0] ld_data = 6'd0;
    logic       ld_label = 1'b0;
    logic       ld_clear = 1'b0;
    logic       start = 1'b0;
    logic       p_done = 1'b0;
    logic       p_class = 1'b0;
    logic       go, update, correct, busy, full, fin, converged, timeout_err;
    logic [5:0] in_val;
    logic [3:0] epoch_cnt;
    logic [2:0] dbg_state;

    training_sequencer #(
        .NUM_FEAT(NUM_FEAT), .DEPTH(DEPTH), .MAX_EPOCHS(MAX_EPOCHS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_l(reset_l), .ld_wr(ld_wr), .ld_data(ld_data),
        .ld_label(ld_label), .ld_clear(ld_clear), .start(start),
        .p_done(p_done), .p_class(p_class), .go(go), .in_val(in_val),
        .update(update), .correct(correct), .busy(busy), .full(full),
        .fin(fin), .converged(converged), .timeout_err(timeout_err),
        .epoch_cnt(epoch_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    // Reference model of the sample store and of the core's answers.
    logic [5:0] feat_m [DEPTH][NUM_FEAT];
    bit         lab_m [DEPTH];
    int         cnt_m = 0;
    bit         cls_tab [128];
    int         core_mode = 0;   // 0: answer label, 1: always 1, 2: never answer, 3: cls_tab
    bit         noise = 1'b0;
    bit         mon_en = 1'b1;

    function automatic logic [W-1:0] ev(input logic [2:0] kind, input logic [8:0] data);
        return {kind, data};
    endfunction

    function automatic bit ref_class(input int mode, input int n, input int s);
        if (mode == 0) return lab_m[s];
        if (mode == 1) return 1'b1;
        return cls_tab[n % 128];
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sb_check(input string nm, input logic [W-1:0] act);
        logic [W-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got event %h but none expected (cycle %0d)", nm, act, cyc);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got event %h expected %h (cycle %0d)", nm, act, e, cyc);
            end
        end
    endtask

    // Whole-run behaviour from the rules: epochs of in-order presentations,
    // stop on a clean epoch, the epoch limit, or a silent core.
    task automatic model_push(input int mode, output bit conv, output bit to, output int ep);
        int errs;
        int n;
        bit c;
        conv = 1'b0;
        to   = 1'b0;
        ep   = 0;
        n    = 0;
        if (cnt_m == 0) begin
            exp_q.push_back(ev(EV_FIN, 9'd0));
            return;
        end
        while (1) begin
            errs = 0;
            for (int s = 0; s < cnt_m; s++) begin
                for (int k = 0; k < NUM_FEAT; k++)
                    exp_q.push_back(ev(EV_FEAT, {2'b00, (k == 0), feat_m[s][k]}));
                if (mode == 2) begin
                    to = 1'b1;
                    exp_q.push_back(ev(EV_FIN, {3'b000, 1'b0, 1'b1, 4'(ep)}));
                    return;
                end
                c = (ref_class(mode, n, s) == lab_m[s]);
                n++;
                exp_q.push_back(ev(EV_UPD, {8'd0, c}));
                if (!c) errs++;
            end
            ep++;
            if (errs == 0) begin
                conv = 1'b1;
                exp_q.push_back(ev(EV_FIN, {3'b000, 1'b1, 1'b0, 4'(ep)}));
                return;
            end
            if (ep == MAX_EPOCHS) begin
                exp_q.push_back(ev(EV_FIN, {3'b000, 1'b0, 1'b0, 4'(ep)}));
                return;
            end
        end
    endtask

    // ---------------- core model ----------------
    int feed_left = 0;
    bit waiting = 1'b0;
    int delay = 0;
    int pres_n = 0;

    always @(negedge clk) begin
        p_done  = 1'b0;
        p_class = 1'b0;
        if (!reset_l) begin
            feed_left = 0;
            waiting   = 1'b0;
            pres_n    = 0;
        end else if (fin) begin
            pres_n  = 0;
            waiting = 1'b0;
        end else if (go) begin
            feed_left = NUM_FEAT - 1;
            waiting   = 1'b0;
        end else if (feed_left > 0) begin
            if (noise && feed_left == NUM_FEAT - 1) begin
                p_done  = 1'b1;
                p_class = 1'($urandom_range(0, 1));
            end
            feed_left--;
            if (feed_left == 0) begin
                waiting = 1'b1;
                delay   = $urandom_range(0, 5);
            end
        end else if (waiting && core_mode != 2) begin
            if (delay == 0) begin
                p_done  = 1'b1;
                p_class = ref_class(core_mode, pres_n, pres_n % cnt_m);
                pres_n++;
                waiting = 1'b0;
            end else begin
                delay--;
            end
        end
    end

    // ---------------- monitor ----------------
    int mon_left = 0;
    int last_feed_cyc = 0;
    int fin_cyc = 0;
    int upd_seen = 0;
    int fin_seen = 0;

    always @(negedge clk) begin
        if (fin) begin
            fin_seen++;
            fin_cyc = cyc;
        end
        if (update) upd_seen++;
        if (!reset_l || !mon_en) begin
            mon_left = 0;
        end else begin
            if (go) begin
                sb_check("feature", ev(EV_FEAT, {2'b00, 1'b1, in_val}));
                mon_left = NUM_FEAT - 1;
            end else if (mon_left > 0) begin
                sb_check("feature", ev(EV_FEAT, {2'b00, 1'b0, in_val}));
                mon_left--;
                if (mon_left == 0) last_feed_cyc = cyc;
            end
            if (update) sb_check("update", ev(EV_UPD, {8'd0, correct}));
            if (fin) sb_check("fin", ev(EV_FIN, {3'b000, converged, timeout_err, epoch_cnt}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_sample(input logic [NUM_FEAT*6-1:0] words, input bit lab);
        for (int k = 0; k < NUM_FEAT; k++) begin
            @(negedge clk);
            ld_wr    = 1'b1;
            ld_data  = words[k*6 +: 6];
            ld_label = lab;
        end
        @(negedge clk);
        ld_wr = 1'b0;
        if (cnt_m < DEPTH) begin
            for (int k = 0; k < NUM_FEAT; k++) feat_m[cnt_m][k] = words[k*6 +: 6];
            lab_m[cnt_m] = lab;
            cnt_m++;
        end
    endtask

    task automatic clear_store();
        @(negedge clk);
        ld_clear = 1'b1;
        @(negedge clk);
        ld_clear = 1'b0;
        cnt_m = 0;
    endtask

    task automatic run_training(input int mode, input bit nz, input string tag);
        bit m_conv, m_to, got;
        int m_ep;
        core_mode = mode;
        noise     = nz;
        model_push(mode, m_conv, m_to, m_ep);
        @(negedge clk);
        start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < BUDGET && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                cmp({tag, "_busy_after_start"}, 32'(busy), 32'd1);
                cmp({tag, "_flags_cleared"}, {26'd0, converged, timeout_err, epoch_cnt}, 32'd0);
            end
            if (fin) begin
                got = 1'b1;
            end else if (nz) begin
                start    = 1'($urandom_range(0, 1));
                ld_wr    = 1'($urandom_range(0, 1));
                ld_data  = 6'($urandom_range(0, 63));
                ld_label = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        ld_wr = 1'b0;
        noise = 1'b0;
        cmp({tag, "_fin_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        cmp({tag, "_busy_after_fin"}, 32'(busy), 32'd0);
        cmp({tag, "_held_result"}, {26'd0, converged, timeout_err, epoch_cnt},
            {26'd0, m_conv, m_to, 4'(m_ep)});
        cmp({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_FEAT*6-1:0] w;
        int upd0, fin0;

        // reset
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        cmp("reset_outputs", {13'd0, go, in_val, update, correct, busy, full, fin,
                              converged, timeout_err, epoch_cnt}, 32'd0);
        cmp("reset_state", 32'(dbg_state), 32'd0);
        reset_l = 1'b1;

        // two samples, core answers with the label: one clean epoch
        load_sample({6'd4, 6'd3, 6'd2, 6'd1}, 1'b1);
        load_sample({6'd8, 6'd7, 6'd6, 6'd5}, 1'b0);
        cmp("full_two_samples", 32'(full), 32'd0);
        run_training(0, 1'b0, "converge");
        cmp("converge_epoch", 32'(epoch_cnt), 32'd1);
        cmp("converge_flag", 32'(converged), 32'd1);

        // core always says 1: second sample always wrong, epoch limit
        upd0 = upd_seen;
        run_training(1, 1'b0, "limit");
        cmp("limit_updates", 32'(upd_seen - upd0), 32'd30);
        cmp("limit_epoch", 32'(epoch_cnt), 32'd15);

        // stray start / ld_wr / p_done during the run change nothing
        upd0 = upd_seen;
        run_training(0, 1'b1, "noise");
        cmp("noise_updates", 32'(upd_seen - upd0), 32'd2);

        // silent core: 256 wait cycles then fin with timeout_err
        run_training(2, 1'b0, "timeout");
        cmp("timeout_wait_len", 32'(fin_cyc - last_feed_cyc), 32'(TIMEOUT + 2));
        cmp("timeout_flag", 32'(timeout_err), 32'd1);
        run_training(0, 1'b0, "after_timeout");

        // randomized stores and core answers
        for (int r = 0; r < 4; r++) begin
            int ns;
            clear_store();
            ns = $urandom_range(1, DEPTH);
            for (int s = 0; s < ns; s++) begin
                for (int k = 0; k < NUM_FEAT; k++) w[k*6 +: 6] = 6'($urandom_range(0, 63));
                load_sample(w, 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < 128; i++) cls_tab[i] = 1'($urandom_range(0, 1));
            run_training(($urandom_range(0, 1) == 1) ? 3 : 0, 1'($urandom_range(0, 1)), "random");
        end

        // capacity: ninth sample is dropped
        clear_store();
        for (int s = 0; s < DEPTH; s++) begin
            for (int k = 0; k < NUM_FEAT; k++) w[k*6 +: 6] = 6'($urandom_range(0, 62));
            load_sample(w, 1'($urandom_range(0, 1)));
        end
        cmp("full_at_depth", 32'(full), 32'd1);
        load_sample({NUM_FEAT{6'd63}}, 1'b1);
        cmp("full_after_extra", 32'(full), 32'd1);
        run_training(0, 1'b0, "full_run");
        clear_store();
        cmp("full_after_clear", 32'(full), 32'd0);
        run_training(0, 1'b0, "empty");

        // reset during FEED of the first sample
        load_sample({6'd4, 6'd3, 6'd2, 6'd1}, 1'b1);
        load_sample({6'd8, 6'd7, 6'd6, 6'd5}, 1'b0);
        mon_en = 1'b0;
        core_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp("rst_go", {25'd0, go, in_val}, {25'd0, 1'b1, 6'd1});
        @(negedge clk);
        cmp("rst_feed1", {25'd0, go, in_val}, {25'd0, 1'b0, 6'd2});
        reset_l = 1'b0;
        fin0 = fin_seen;
        @(negedge clk);
        cmp("midrun_reset_outputs", {13'd0, go, in_val, update, correct, busy, full, fin,
                                     converged, timeout_err, epoch_cnt}, 32'd0);
        cmp("midrun_reset_state", 32'(dbg_state), 32'd0);
        reset_l = 1'b1;
        cnt_m = 0;
        repeat (6) @(negedge clk);
        cmp("midrun_reset_no_fin", 32'(fin_seen - fin0), 32'd0);
        mon_en = 1'b1;
        run_training(0, 1'b0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
